// File: rtl/rtc_prog_ctrl.sv
// Programming-mode controller: BCD field editing with a cursor, then a 3-write req/ack commit on mode exit.
// Optional timer group (mode 11) is built when PROG_TIMER_EN is defined; otherwise mode 11 behaves like 00.
module rtc_prog_ctrl #(
  parameter logic [7:0] DIR_FECHA = 8'h24,
  parameter logic [7:0] DIR_HORA  = 8'h21,
  parameter logic [7:0] DIR_TIMER = 8'h41
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] programacion,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       wr_ack,
  output logic       editing,
  output logic [1:0] campo,
  output logic [7:0] valor,
  output logic       wr_req,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       done
);

  typedef enum logic [2:0] {S_IDLE, S_EDIT, S_WREQ, S_WGAP, S_DONE} state_t;

  localparam logic [1:0] M_NONE  = 2'b00;
  localparam logic [1:0] M_FECHA = 2'b01;
  localparam logic [1:0] M_HORA  = 2'b10;
  localparam logic [1:0] M_TIMER = 2'b11;

  state_t          state_q, state_d;
  logic [1:0]      modo_q, modo_d;
  logic [1:0]      campo_q, campo_d;
  logic [1:0]      idx_q, idx_d;
  logic [2:0][7:0] fecha_q, fecha_d;
  logic [2:0][7:0] hora_q, hora_d;
`ifdef PROG_TIMER_EN
  logic [2:0][7:0] timer_q, timer_d;
`endif

  logic [1:0]      prog_eff;
  logic [2:0][7:0] grp;
  logic [7:0]      cur_val;
  logic [7:0]      new_val;
  logic [7:0]      wr_val;
  logic [7:0]      wr_base;

  function automatic logic [7:0] fld_min(input logic [1:0] m, input logic [1:0] k);
    return (m == M_FECHA && k != 2'd2) ? 8'h01 : 8'h00;
  endfunction

  function automatic logic [7:0] fld_max(input logic [1:0] m, input logic [1:0] k);
    if (m == M_FECHA) begin
      if (k == 2'd0) return 8'h31;
      if (k == 2'd1) return 8'h12;
      return 8'h99;
    end
    return (k == 2'd0) ? 8'h23 : 8'h59;
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lo, input logic [7:0] hi);
    if (v == hi) return lo;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return v + 8'd1;
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] lo, input logic [7:0] hi);
    if (v == lo) return hi;
    if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    return v - 8'd1;
  endfunction

  // Without the timer group, mode 11 is indistinguishable from "no mode".
  always_comb begin
    prog_eff = programacion;
`ifndef PROG_TIMER_EN
    if (programacion == M_TIMER) prog_eff = M_NONE;
`endif
  end

  always_comb begin
    grp = '0;
    case (modo_q)
      M_FECHA: grp = fecha_q;
      M_HORA:  grp = hora_q;
`ifdef PROG_TIMER_EN
      M_TIMER: grp = timer_q;
`endif
      default: grp = '0;
    endcase
  end

  always_comb begin
    cur_val = grp[2];
    case (campo_q)
      2'd0:    cur_val = grp[0];
      2'd1:    cur_val = grp[1];
      default: cur_val = grp[2];
    endcase
  end

  always_comb begin
    wr_val = grp[2];
    case (idx_q)
      2'd0:    wr_val = grp[0];
      2'd1:    wr_val = grp[1];
      default: wr_val = grp[2];
    endcase
  end

  always_comb begin
    new_val = cur_val;
    if (btn_up && !btn_down)
      new_val = bcd_inc(cur_val, fld_min(modo_q, campo_q), fld_max(modo_q, campo_q));
    else if (btn_down && !btn_up)
      new_val = bcd_dec(cur_val, fld_min(modo_q, campo_q), fld_max(modo_q, campo_q));
  end

  // Date fields go out in ascending address order; time/timer fields descend from base+2.
  always_comb begin
    wr_base = 8'h00;
    case (modo_q)
      M_FECHA: wr_base = DIR_FECHA + {6'd0, idx_q};
      M_HORA:  wr_base = DIR_HORA + (8'd2 - {6'd0, idx_q});
`ifdef PROG_TIMER_EN
      M_TIMER: wr_base = DIR_TIMER + (8'd2 - {6'd0, idx_q});
`endif
      default: wr_base = 8'h00;
    endcase
  end

  always_comb begin
    state_d = state_q;
    modo_d  = modo_q;
    campo_d = campo_q;
    idx_d   = idx_q;
    fecha_d = fecha_q;
    hora_d  = hora_q;
`ifdef PROG_TIMER_EN
    timer_d = timer_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (prog_eff != M_NONE) begin
          state_d = S_EDIT;
          modo_d  = prog_eff;
          campo_d = 2'd0;
        end
      end
      S_EDIT: begin
        case (modo_q)
          M_FECHA: fecha_d[campo_q] = new_val;
          M_HORA:  hora_d[campo_q]  = new_val;
`ifdef PROG_TIMER_EN
          M_TIMER: timer_d[campo_q] = new_val;
`endif
          default: ;
        endcase
        if (btn_right && !btn_left)
          campo_d = (campo_q == 2'd2) ? 2'd0 : campo_q + 2'd1;
        else if (btn_left && !btn_right)
          campo_d = (campo_q == 2'd0) ? 2'd2 : campo_q - 2'd1;
        if (prog_eff != modo_q) begin
          state_d = S_WREQ;
          idx_d   = 2'd0;
        end
      end
      S_WREQ: begin
        if (wr_ack) begin
          if (idx_q == 2'd2) begin
            state_d = S_DONE;
          end else begin
            state_d = S_WGAP;
            idx_d   = idx_q + 2'd1;
          end
        end
      end
      S_WGAP:  state_d = S_WREQ;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      modo_q  <= M_NONE;
      campo_q <= 2'd0;
      idx_q   <= 2'd0;
      fecha_q <= {8'h00, 8'h01, 8'h01};
      hora_q  <= '0;
`ifdef PROG_TIMER_EN
      timer_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      modo_q  <= modo_d;
      campo_q <= campo_d;
      idx_q   <= idx_d;
      fecha_q <= fecha_d;
      hora_q  <= hora_d;
`ifdef PROG_TIMER_EN
      timer_q <= timer_d;
`endif
    end
  end

  // Outputs decode straight from the state flop so reset drops wr_req without waiting for an edge.
  assign editing = (state_q == S_EDIT);
  assign wr_req  = (state_q == S_WREQ);
  assign done    = (state_q == S_DONE);
  assign campo   = campo_q;
  assign valor   = cur_val;
  assign wr_addr = wr_req ? wr_base : 8'h00;
  assign wr_data = wr_req ? wr_val : 8'h00;

endmodule

// File: tb/tb_rtc_prog_ctrl.sv
// Directed bench for rtc_prog_ctrl: editing, cursor, BCD wraps, commit handshake, reset abort, mode 01->11.
module tb_rtc_prog_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] programacion;
  logic       btn_up, btn_down, btn_left, btn_right;
  logic       wr_ack;
  logic       editing;
  logic [1:0] campo;
  logic [7:0] valor;
  logic       wr_req;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       done;

  int checks = 0;
  int errors = 0;

  rtc_prog_ctrl dut (
    .clk(clk), .reset(reset), .programacion(programacion),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .wr_ack(wr_ack), .editing(editing), .campo(campo), .valor(valor),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic up, input logic dn, input logic lf, input logic rt);
    btn_up = up; btn_down = dn; btn_left = lf; btn_right = rt;
    tick();
    btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
  endtask

  task automatic press_n(input int n, input logic up, input logic dn);
    for (int i = 0; i < n; i++) press(up, dn, 1'b0, 1'b0);
  endtask

  task automatic do_write(input string tag, input logic [7:0] ea, input logic [7:0] ed, input int dly);
    int n;
    n = 0;
    while (wr_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_req"}, wr_req, 1);
    chk({tag, "_addr"}, wr_addr, ea);
    chk({tag, "_data"}, wr_data, ed);
    for (int i = 0; i < dly; i++) begin
      tick();
      chk({tag, "_hold_req"}, wr_req, 1);
      chk({tag, "_hold_addr"}, wr_addr, ea);
      chk({tag, "_hold_data"}, wr_data, ed);
    end
    wr_ack = 1'b1;
    tick();
    wr_ack = 1'b0;
    chk({tag, "_drop"}, wr_req, 0);
  endtask

  task automatic commit3(input string tag,
                         input logic [7:0] a0, input logic [7:0] d0,
                         input logic [7:0] a1, input logic [7:0] d1,
                         input logic [7:0] a2, input logic [7:0] d2, input int dly);
    do_write({tag, "_w0"}, a0, d0, dly);
    chk({tag, "_gap0_done"}, done, 0);
    tick();
    chk({tag, "_gap0_len"}, wr_req, 1);
    do_write({tag, "_w1"}, a1, d1, dly);
    tick();
    chk({tag, "_gap1_len"}, wr_req, 1);
    do_write({tag, "_w2"}, a2, d2, dly);
    chk({tag, "_done_hi"}, done, 1);
    tick();
    chk({tag, "_done_lo"}, done, 0);
    chk({tag, "_idle"}, editing, 0);
  endtask

  initial begin
    reset = 1'b1; programacion = 2'b00; wr_ack = 1'b0;
    btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
    #2;
    chk("rst_editing", editing, 0);
    chk("rst_campo", campo, 0);
    chk("rst_wr_req", wr_req, 0);
    chk("rst_wr_addr", wr_addr, 8'h00);
    chk("rst_wr_data", wr_data, 8'h00);
    chk("rst_done", done, 0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // Date: day 01 down wraps to 31
    programacion = 2'b01;
    tick();
    chk("date_editing", editing, 1);
    chk("date_campo0", campo, 0);
    chk("date_day_rst", valor, 8'h01);
    press(0, 1, 0, 0);
    chk("day_wrap_down", valor, 8'h31);

    // Month 01 down wraps to 12, then up+right together on field 1
    press(0, 0, 0, 1);
    chk("cursor_right", campo, 1);
    chk("month_rst", valor, 8'h01);
    press(0, 1, 0, 0);
    chk("month_wrap_down", valor, 8'h12);
    press(1, 0, 0, 1);
    chk("upright_campo", campo, 2);
    chk("upright_year", valor, 8'h00);
    press(0, 0, 1, 0);
    chk("month_wrap_up", valor, 8'h01);
    press(1, 1, 1, 1);
    chk("both_pairs_campo", campo, 1);
    chk("both_pairs_val", valor, 8'h01);

    // Switching 01 -> 10 commits the date, then enters time editing
    programacion = 2'b10;
    commit3("date1", 8'h24, 8'h31, 8'h25, 8'h01, 8'h26, 8'h00, 0);
    tick();
    chk("time_editing", editing, 1);
    chk("time_campo0", campo, 0);
    chk("time_hours_rst", valor, 8'h00);

    press_n(23, 1, 0);
    chk("hours_23", valor, 8'h23);
    press(1, 0, 0, 0);
    chk("hours_wrap_up", valor, 8'h00);
    press(0, 0, 1, 0);
    chk("cursor_left_wrap", campo, 2);

    // Build 12:34:56
    press_n(56, 1, 0);
    chk("seconds_56", valor, 8'h56);
    press(0, 0, 1, 0);
    press_n(34, 1, 0);
    chk("minutes_34", valor, 8'h34);
    press(0, 1, 0, 0);
    chk("minutes_dec", valor, 8'h33);
    press(1, 0, 0, 0);
    press(0, 0, 1, 0);
    chk("cursor_to_0", campo, 0);
    press_n(12, 1, 0);
    chk("hours_12", valor, 8'h12);

    // Commit time with ack two cycles into each request
    programacion = 2'b00;
    commit3("time", 8'h23, 8'h12, 8'h22, 8'h34, 8'h21, 8'h56, 2);
    tick();
    chk("idle_stays", editing, 0);

    // Buttons in IDLE are ignored; fields survive the exit
    press(1, 0, 0, 0);
    programacion = 2'b10;
    tick();
    chk("reenter_editing", editing, 1);
    chk("hours_held", valor, 8'h12);

    // Reset during the second write
    programacion = 2'b00;
    do_write("abort_w0", 8'h23, 8'h12, 0);
    tick();
    chk("abort_w1_req", wr_req, 1);
    chk("abort_w1_addr", wr_addr, 8'h22);
    reset = 1'b1;
    #1;
    chk("abort_req_async", wr_req, 0);
    chk("abort_addr", wr_addr, 8'h00);
    chk("abort_editing", editing, 0);
    tick();
    reset = 1'b0;
    tick();
    chk("abort_idle", editing, 0);
    chk("abort_done", done, 0);

    // Time fields back to 00 after reset, observed through a commit
    programacion = 2'b10;
    tick();
    chk("post_rst_hours", valor, 8'h00);
    programacion = 2'b00;
    commit3("time0", 8'h23, 8'h00, 8'h22, 8'h00, 8'h21, 8'h00, 0);

    // Date fields back to 01/01/00
    programacion = 2'b01;
    tick();
    chk("post_rst_day", valor, 8'h01);
    press(0, 0, 0, 1);
    chk("post_rst_month", valor, 8'h01);
    press(0, 0, 0, 1);
    chk("post_rst_year", valor, 8'h00);

    // Direct 01 -> 11 commits the date in both builds
    programacion = 2'b11;
    commit3("date2", 8'h24, 8'h01, 8'h25, 8'h01, 8'h26, 8'h00, 1);
`ifdef PROG_TIMER_EN
    tick();
    chk("timer_editing", editing, 1);
    chk("timer_hours_rst", valor, 8'h00);
    press(1, 0, 0, 0);
    chk("timer_hours_up", valor, 8'h01);
    programacion = 2'b00;
    commit3("timer", 8'h43, 8'h01, 8'h42, 8'h00, 8'h41, 8'h00, 0);
`else
    repeat (3) tick();
    chk("mode11_idle", editing, 0);
    chk("mode11_no_req", wr_req, 0);
    programacion = 2'b00;
    tick();
    chk("mode00_idle", editing, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
